// File: rtl/sim_test_monitor.sv
// End-of-test monitor for multi-hart simulation tops. Watches the per-hart done/result/testnum
// register taps and a cycle counter, then latches a single PASS / FAIL / TIMEOUT verdict.
module sim_test_monitor #(
    parameter int                    NUM_HARTS     = 1,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] DONE_VALUE    = DATA_WIDTH'(1),
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE    = DATA_WIDTH'(1),
    parameter int                    SETTLE_CYCLES = 10,
    parameter int                    TIMEOUT_BIT   = 20,
    localparam int                   HART_W        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_HARTS-1:0]             hart_en_i,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0]  done_i,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0]  result_i,
    input  logic [NUM_HARTS*DATA_WIDTH-1:0]  testnum_i,
    input  logic                             timeout_dis_i,
    output logic                             busy_o,
    output logic                             finish_o,
    output logic                             pass_o,
    output logic                             fail_o,
    output logic                             timeout_o,
    output logic [HART_W-1:0]                fail_hart_o,
    output logic [DATA_WIDTH-1:0]            fail_testnum_o,
    output logic [TIMEOUT_BIT:0]             cycle_count_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W = TIMEOUT_BIT + 1;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [SET_W-1:0]      settle_cnt;
    logic [CNT_W-1:0]      cycle_count;
    logic                  all_done;
    logic                  any_fail;
    logic [HART_W-1:0]     first_fail_hart;
    logic [DATA_WIDTH-1:0] first_fail_testnum;
    logic                  settle_last;
    logic                  timeout_hit;
    logic                  enter_done;

    // With no hart enabled the test can never be considered done.
    always_comb begin
        all_done = |hart_en_i;
        for (int k = 0; k < NUM_HARTS; k++) begin
            if (hart_en_i[k] && (done_i[k*DATA_WIDTH +: DATA_WIDTH] != DONE_VALUE)) begin
                all_done = 1'b0;
            end
        end
    end

    // Scan from the top down so the lowest-index failing hart is the one left standing.
    always_comb begin
        any_fail           = 1'b0;
        first_fail_hart    = '0;
        first_fail_testnum = '0;
        for (int k = NUM_HARTS - 1; k >= 0; k--) begin
            if (hart_en_i[k] && (result_i[k*DATA_WIDTH +: DATA_WIDTH] != PASS_VALUE)) begin
                any_fail           = 1'b1;
                first_fail_hart    = HART_W'(k);
                first_fail_testnum = testnum_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign settle_last = (state == ST_SETTLE) && (settle_cnt == '0);
    assign timeout_hit = !timeout_dis_i && cycle_count[TIMEOUT_BIT];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (all_done) begin
                    state_nxt = ST_SETTLE;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_RUN) && all_done) begin
                settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
            end else if ((state == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
        end
    end

    // The counter stops on the cycle that enters DONE and saturates if timeout is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if ((state_nxt != ST_DONE) && !(&cycle_count)) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            finish_o       <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            timeout_o      <= 1'b0;
            fail_hart_o    <= '0;
            fail_testnum_o <= '0;
        end else begin
            finish_o <= enter_done;
            if ((state == ST_RUN) && enter_done) begin
                timeout_o <= 1'b1;
            end
            if (settle_last) begin
                if (any_fail) begin
                    fail_o         <= 1'b1;
                    fail_hart_o    <= first_fail_hart;
                    fail_testnum_o <= first_fail_testnum;
                end else begin
                    pass_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o        = (state != ST_DONE);
    assign cycle_count_o = cycle_count;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Scoreboard bench for sim_test_monitor: directed runs push the expected verdict, and a
// negedge monitor pops and compares it whenever finish_o pulses.
module tb_sim_test_monitor;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int SC = 4;
    localparam int TB = 6;
    localparam int HW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NH-1:0]     hart_en;
    logic [NH*DW-1:0]  done;
    logic [NH*DW-1:0]  result;
    logic [NH*DW-1:0]  testnum;
    logic              timeout_dis;
    logic              busy_o;
    logic              finish_o;
    logic              pass_o;
    logic              fail_o;
    logic              timeout_o;
    logic [HW-1:0]     fail_hart_o;
    logic [DW-1:0]     fail_testnum_o;
    logic [TB:0]       cycle_count_o;

    sim_test_monitor #(
        .NUM_HARTS(NH), .DATA_WIDTH(DW), .DONE_VALUE(32'd1), .PASS_VALUE(32'd1),
        .SETTLE_CYCLES(SC), .TIMEOUT_BIT(TB)
    ) dut (
        .clk(clk), .rst(rst), .hart_en_i(hart_en), .done_i(done), .result_i(result),
        .testnum_i(testnum), .timeout_dis_i(timeout_dis), .busy_o(busy_o),
        .finish_o(finish_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .fail_hart_o(fail_hart_o), .fail_testnum_o(fail_testnum_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pass;
        logic          fail;
        logic          tmo;
        logic [HW-1:0] hart;
        logic [DW-1:0] tn;
        int            fin_cycle;
        int            count;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t last_exp;
    bit   have_last = 1'b0;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    // Cycle index since reset release, used only as a time reference for expectations.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_verdict(input exp_t e);
        check_output("pass_o", pass_o, e.pass);
        check_output("fail_o", fail_o, e.fail);
        check_output("timeout_o", timeout_o, e.tmo);
        check_output("fail_hart_o", fail_hart_o, e.hart);
        check_output("fail_testnum_o", fail_testnum_o, e.tn);
        check_output("busy_o_done", busy_o, 0);
        check_output("cycle_count_frozen", cycle_count_o, e.count);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (finish_o) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_finish", finish_o, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_output("finish_cycle", cyc, mon_e.fin_cycle);
                    check_verdict(mon_e);
                    last_exp  = mon_e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                check_verdict(last_exp);
            end
        end
    end

    task automatic set_hart(input int k, input logic [DW-1:0] d, input logic [DW-1:0] r,
                            input logic [DW-1:0] t);
        done[k*DW +: DW]    = d;
        result[k*DW +: DW]  = r;
        testnum[k*DW +: DW] = t;
    endtask

    task automatic push_exp(input logic p, input logic f, input logic t, input logic [HW-1:0] h,
                            input logic [DW-1:0] tn, input int fin, input int cnt);
        exp_t e;
        e.pass = p; e.fail = f; e.tmo = t; e.hart = h; e.tn = tn;
        e.fin_cycle = fin; e.count = cnt;
        sb_q.push_back(e);
    endtask

    // Leaves the caller at posedge+1 of cycle 0 with all inputs idle.
    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        hart_en = '0; done = '0; result = '0; testnum = '0; timeout_dis = 1'b0;
        sb_q.delete();
        have_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("rst_busy_o", busy_o, 1);
        check_output("rst_finish_o", finish_o, 0);
        check_output("rst_pass_o", pass_o, 0);
        check_output("rst_fail_o", fail_o, 0);
        check_output("rst_timeout_o", timeout_o, 0);
        check_output("rst_fail_hart_o", fail_hart_o, 0);
        check_output("rst_fail_testnum_o", fail_testnum_o, 0);
        check_output("rst_cycle_count_o", cycle_count_o, 0);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_finish();
        int n = 0;
        while ((sb_q.size() != 0) && (n < 300)) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check_output("finish_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_stimulus();
        $display("[TB] single enabled hart passes");
        apply_reset();
        hart_en = 2'b01; set_hart(0, 0, 1, 11); set_hart(1, 0, 0, 99);
        push_exp(1, 0, 0, 0, 0, 15, 14);
        step_to(10); set_hart(0, 1, 1, 11);
        wait_finish();

        $display("[TB] hart1 fails");
        apply_reset();
        hart_en = 2'b11; set_hart(0, 0, 1, 3); set_hart(1, 0, 0, 7);
        push_exp(0, 1, 0, 1, 7, 25, 24);
        step_to(20); set_hart(0, 1, 1, 3); set_hart(1, 1, 0, 7);
        wait_finish();

        $display("[TB] both harts fail, lowest index reported");
        apply_reset();
        hart_en = 2'b11; set_hart(0, 0, 5, 3); set_hart(1, 0, 0, 7);
        push_exp(0, 1, 0, 0, 3, 25, 24);
        step_to(20); set_hart(0, 1, 5, 3); set_hart(1, 1, 0, 7);
        wait_finish();

        $display("[TB] timeout");
        apply_reset();
        hart_en = 2'b11; set_hart(0, 0, 1, 1); set_hart(1, 0, 1, 1);
        push_exp(0, 0, 1, 0, 0, 65, 64);
        wait_finish();

        $display("[TB] timeout disabled then re-enabled");
        apply_reset();
        hart_en = 2'b11; timeout_dis = 1'b1;
        step_to(200);
        check_output("busy_at_200", busy_o, 1);
        check_output("count_saturated", cycle_count_o, 127);
        push_exp(0, 0, 1, 0, 0, 201, 127);
        timeout_dis = 1'b0;
        wait_finish();

        $display("[TB] all_done coincides with timeout bit");
        apply_reset();
        hart_en = 2'b01; set_hart(0, 0, 1, 2);
        push_exp(1, 0, 0, 0, 0, 69, 68);
        step_to(64); set_hart(0, 1, 1, 2);
        wait_finish();

        $display("[TB] disabled hart ignored");
        apply_reset();
        hart_en = 2'b01; set_hart(1, 0, 0, 42); set_hart(0, 0, 1, 5);
        push_exp(1, 0, 0, 0, 0, 17, 16);
        step_to(12); set_hart(0, 1, 1, 5);
        wait_finish();

        $display("[TB] no hart enabled never completes");
        apply_reset();
        hart_en = 2'b00; set_hart(0, 1, 1, 0); set_hart(1, 1, 1, 0);
        push_exp(0, 0, 1, 0, 0, 65, 64);
        wait_finish();

        $display("[TB] reset mid-settle then rerun");
        apply_reset();
        hart_en = 2'b11; set_hart(0, 0, 1, 0); set_hart(1, 0, 1, 0);
        push_exp(1, 0, 0, 0, 0, 15, 14);
        step_to(10); set_hart(0, 1, 1, 0); set_hart(1, 1, 1, 0);
        step_to(12);
        apply_reset();
        hart_en = 2'b11; set_hart(0, 0, 1, 0); set_hart(1, 0, 1, 0);
        push_exp(1, 0, 0, 0, 0, 10, 9);
        step_to(5); set_hart(0, 1, 1, 0); set_hart(1, 1, 1, 0);
        wait_finish();
        repeat (10) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        hart_en = '0; done = '0; result = '0; testnum = '0; timeout_dis = 1'b0;
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
